// File: rtl/bram_arb_pkg.sv
// Shared constants and response-tag type for the BRAM bank arbiter and the BRAM controllers.
package bram_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 13;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_READ_LATENCY = 10;
  // Tag id is sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W         = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

  // Requester id width: $clog2(n), never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_bank_arbiter_rr.sv
// Round-robin grant with pointer register; BRAM_ARB_HIPRI_EN gives requester 0 absolute priority.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_id_c
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            upd;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    found      = 1'b0;
    upd        = 1'b0;
    idx        = '0;
    rr_ptr_d   = rr_ptr_q;
`ifdef BRAM_ARB_HIPRI_EN
    if (req[0]) begin
      grant_c[0] = 1'b1;
      found      = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
`ifdef BRAM_ARB_HIPRI_EN
      if (!found && req[idx] && (idx != '0)) begin
`else
      if (!found && req[idx]) begin
`endif
        grant_c[idx] = 1'b1;
        grant_id_c   = idx;
        found        = 1'b1;
        upd          = 1'b1;
      end
    end
    if (accept && upd) begin
      rr_ptr_d = ID_W'((32'(grant_id_c) + 32'd1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/bram_bank_arbiter.sv
// NUM_REQ-way round-robin arbiter onto one fixed-latency single-port BRAM with tagged read returns.
// Optional macro BRAM_ARB_HIPRI_EN: requester 0 gets absolute priority.
module bram_bank_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned ADDR_W       = DEF_ADDR_W,
  parameter  int unsigned DATA_W       = DEF_DATA_W,
  parameter  int unsigned READ_LATENCY = DEF_READ_LATENCY,
  localparam int unsigned CNT_W        = $clog2(READ_LATENCY + 2)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      bram_en,
  output logic                      bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [DATA_W-1:0]         bram_wdata,
  input  logic [DATA_W-1:0]         bram_rdata,
  output logic [CNT_W-1:0]          rd_inflight
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned DEPTH = READ_LATENCY + 1;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_id_c;
  logic               accept_c;
  logic               rd_issue_c;
  logic               rd_retire_c;

  logic               bram_en_q, bram_en_d;
  logic               bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]  bram_wdata_q, bram_wdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]   rd_inflight_q, rd_inflight_d;
  rd_tag_t            tag_q [DEPTH];
  rd_tag_t            tag_d [DEPTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .req        (req_valid),
    .accept     (accept_c),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c)
  );

  // No grant while reset is held.
  assign req_ready = wb_rst_ni ? grant_c : '0;
  assign accept_c  = |(req_valid & req_ready);

  always_comb begin
    rd_issue_c   = accept_c && !req_we[grant_id_c];
    bram_en_d    = accept_c;
    bram_we_d    = accept_c && req_we[grant_id_c];
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    if (accept_c) begin
      bram_addr_d  = req_addr[32'(grant_id_c)*ADDR_W +: ADDR_W];
      bram_wdata_d = req_wdata[32'(grant_id_c)*DATA_W +: DATA_W];
    end
    // Tag shift register: a read's tag leaves the last stage as its data is sampled.
    tag_d[0] = '{valid: rd_issue_c, id: TAG_ID_W'(grant_id_c)};
    for (int unsigned k = 1; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rd_retire_c = tag_q[DEPTH-1].valid;
    rsp_valid_d = '0;
    if (rd_retire_c) begin
      rsp_valid_d[tag_q[DEPTH-1].id] = 1'b1;
    end
    rsp_rdata_d   = rd_retire_c ? bram_rdata : rsp_rdata_q;
    rd_inflight_d = rd_inflight_q + CNT_W'(rd_issue_c) - CNT_W'(rd_retire_c);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bram_en_q     <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_wdata_q  <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rd_inflight_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      bram_en_q     <= bram_en_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_wdata_q  <= bram_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rd_inflight_q <= rd_inflight_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bram_en     = bram_en_q;
  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wdata  = bram_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rd_inflight = rd_inflight_q;

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed bench for bram_bank_arbiter with a write-first fixed-latency BRAM model.
module tb_bram_bank_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned ADDR_W       = 13;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned READ_LATENCY = 10;
  localparam int unsigned CNT_W        = $clog2(READ_LATENCY + 2);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid, req_we, req_ready, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, bram_wdata, bram_rdata;
  logic                      bram_en, bram_we;
  logic [ADDR_W-1:0]         bram_addr;
  logic [CNT_W-1:0]          rd_inflight;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_bank_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .rd_inflight(rd_inflight)
  );

  // BRAM model: writes land at the strobe edge, reads return READ_LATENCY cycles after the strobe.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [READ_LATENCY];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    rd_pipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 32'hBAD0_BAD0;
    for (int k = 1; k < READ_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_rdata = rd_pipe[READ_LATENCY-1];

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); clear_reqs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(negedge clk); clear_reqs(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear_reqs();
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL reset_bram_en: got %b want 0", bram_en); end
    n_cmp++; if (bram_we !== 1'b0) begin n_err++; $display("FAIL reset_bram_we: got %b want 0", bram_we); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (bram_addr !== 13'h0) begin n_err++; $display("FAIL reset_bram_addr: got %h want 0", bram_addr); end
    n_cmp++; if (bram_wdata !== 32'h0) begin n_err++; $display("FAIL reset_bram_wdata: got %h want 0", bram_wdata); end
    n_cmp++; if (rd_inflight !== 4'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", rd_inflight); end
    clear_reqs();
    preload(13'h005, 32'hDEAD_BEEF);
    preload(13'h010, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) preload(ADDR_W'(32'h20 + i), 32'hA000_0000 + i);
    for (int i = 0; i < 10; i++) preload(ADDR_W'(32'h40 + i), 32'h5000_0000 + i);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic early = 1'b0;
    @(negedge clk); clear_reqs(); set_req(2, 1'b0, 13'h005, 32'h0); #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); clear_reqs(); #1;
      if (k == 1) begin
        n_cmp++; if ({bram_en, bram_we} !== 2'b10) begin n_err++; $display("FAIL single_issue: en/we got %b want 10", {bram_en, bram_we}); end
        n_cmp++; if (bram_addr !== 13'h005) begin n_err++; $display("FAIL single_addr: got %h want 005", bram_addr); end
        n_cmp++; if (rd_inflight !== 4'd1) begin n_err++; $display("FAIL single_inflight: got %0d want 1", rd_inflight); end
      end
      if (k == 2) begin
        n_cmp++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL single_en_pulse: got %b want 0", bram_en); end
      end
      if (k < 12 && rsp_valid !== 4'b0000) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL single_early_rsp: got %b want 0", early); end
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_rsp_rdata: got %h want deadbeef", rsp_rdata); end
    n_cmp++; if (rd_inflight !== 4'd0) begin n_err++; $display("FAIL single_inflight_end: got %0d want 0", rd_inflight); end
    drain(2);
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); clear_reqs();
      if (k < 8) for (int i = 0; i < 4; i++) set_req(i, 1'b0, ADDR_W'(32'h20 + i), 32'h0);
      #1;
      if (k < 8) begin
        exp = 4'b0001 << (k % 4);
        n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, exp); end
      end
      if (k >= 12) begin
        exp = 4'b0001 << ((k - 12) % 4);
        n_cmp++; if (rsp_valid !== exp) begin n_err++; $display("FAIL fair_rsp%0d: got %b want %b", k, rsp_valid, exp); end
        n_cmp++; if (rsp_rdata !== 32'hA000_0000 + 32'((k - 12) % 4)) begin
          n_err++; $display("FAIL fair_data%0d: got %h want %h", k, rsp_rdata, 32'hA000_0000 + 32'((k - 12) % 4));
        end
      end
    end
    drain(2);
  endtask

  task automatic test_write_then_read();
    @(negedge clk); clear_reqs(); set_req(3, 1'b1, 13'h010, 32'h0000_1234); #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wr_grant: got %b want 1000", req_ready); end
    @(negedge clk); clear_reqs(); set_req(1, 1'b0, 13'h010, 32'h0); #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_grant: got %b want 0010", req_ready); end
    n_cmp++; if ({bram_en, bram_we} !== 2'b11) begin n_err++; $display("FAIL wr_strobe: en/we got %b want 11", {bram_en, bram_we}); end
    n_cmp++; if (bram_wdata !== 32'h0000_1234) begin n_err++; $display("FAIL wr_data: got %h want 00001234", bram_wdata); end
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk); clear_reqs(); #1;
      if (k == 2) begin
        n_cmp++; if ({bram_en, bram_we} !== 2'b10) begin n_err++; $display("FAIL rd_strobe: en/we got %b want 10", {bram_en, bram_we}); end
      end
    end
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL wtr_rsp_valid: got %b want 0010", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL wtr_rsp_rdata: got %h want 00001234", rsp_rdata); end
    drain(2);
  endtask

  task automatic test_hipri();
    logic [3:0] exp;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clear_reqs();
      if (k < 3) set_req(0, 1'b0, 13'h020, 32'h0);
      set_req(2, 1'b0, 13'h022, 32'h0);
      #1;
`ifdef BRAM_ARB_HIPRI_EN
      exp = (k < 3) ? 4'b0001 : 4'b0100;
`else
      exp = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL hipri_grant%0d: got %b want %b", k, req_ready, exp); end
    end
    drain(16);
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); clear_reqs(); set_req(1, 1'b0, 13'h021, 32'h0);
    end
    @(negedge clk); clear_reqs(); #1;
    n_cmp++; if (rd_inflight !== 4'd3) begin n_err++; $display("FAIL mid_inflight_pre: got %0d want 3", rd_inflight); end
    repeat (4) @(negedge clk);
    rst_n = 1'b0; req_valid = '1; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
    n_cmp++; if (rd_inflight !== 4'd0) begin n_err++; $display("FAIL mid_inflight_reset: got %0d want 0", rd_inflight); end
    @(negedge clk); clear_reqs(); rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 4'b0000) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale_rsp: got %b want 0", seen); end
    n_cmp++; if (rd_inflight !== 4'd0) begin n_err++; $display("FAIL mid_inflight_after: got %0d want 0", rd_inflight); end
    @(negedge clk); for (int i = 0; i < 4; i++) set_req(i, 1'b0, ADDR_W'(32'h20 + i), 32'h0); #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_next_grant: got %b want 0001", req_ready); end
    drain(16);
  endtask

  task automatic test_counter();
    int peak = 0;
    int n_rsp = 0;
    int last_rsp = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk); clear_reqs();
      if (k < 10) set_req(2, 1'b0, ADDR_W'(32'h40 + k), 32'h0);
      #1;
      if (int'(rd_inflight) > peak) peak = int'(rd_inflight);
      if (rsp_valid !== 4'b0000) begin
        n_rsp++; last_rsp = k;
        n_cmp++; if (rsp_rdata !== 32'h5000_0000 + 32'(k - 12)) begin
          n_err++; $display("FAIL cnt_data%0d: got %h want %h", k, rsp_rdata, 32'h5000_0000 + 32'(k - 12));
        end
      end
      if (k == 11) begin
        n_cmp++; if (rd_inflight !== 4'd10) begin n_err++; $display("FAIL cnt_k11: got %0d want 10", rd_inflight); end
      end
      if (k == 20) begin
        n_cmp++; if (rd_inflight !== 4'd1) begin n_err++; $display("FAIL cnt_k20: got %0d want 1", rd_inflight); end
      end
      if (k == 21) begin
        n_cmp++; if ({rsp_valid, rd_inflight} !== {4'b0100, 4'd0}) begin
          n_err++; $display("FAIL cnt_final: rsp/inflight got %b/%0d want 0100/0", rsp_valid, rd_inflight);
        end
      end
    end
    n_cmp++; if (peak != 10) begin n_err++; $display("FAIL cnt_peak: got %0d want 10", peak); end
    n_cmp++; if (n_rsp != 10) begin n_err++; $display("FAIL cnt_rsp_count: got %0d want 10", n_rsp); end
    n_cmp++; if (last_rsp != 21) begin n_err++; $display("FAIL cnt_last_rsp: got %0d want 21", last_rsp); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_write_then_read();
    test_hipri();
    test_reset_midflight();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_bank_arbiter.md
# bram_bank_arbiter

Parametrised successor to the fixed three-way BRAM arbiter in the user project. It arbitrates NUM_REQ independent requesters (instruction cache, data FIFO prefetch, DMA read, DMA write, …) onto one single-port BRAM with fixed read latency, using round-robin grant. Read data returns to the issuing requester through a tagged response pipeline. It sits between the Wishbone-side clients and one BRAM bank, replacing per-bank hard-wired `reader_sel` muxing.

## Interface
- NUM_REQ, 4: number of requesters, 1..8
- ADDR_W, 13: word address width
- DATA_W, 32: data width
- READ_LATENCY, 10: cycles from `bram_en` (read) to valid `bram_rdata`, ≥1
---
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot grant; acceptance = valid & ready
- rsp_valid  out  NUM_REQ  one-hot read-data valid, single-cycle pulse
- rsp_rdata  out  DATA_W  read data shared by all requesters
- bram_en  out  1  BRAM access strobe
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data
- rd_inflight  out  $clog2(READ_LATENCY+2)  reads issued but not yet returned

## Operation
- Grant is combinational from `req_valid` and the round-robin pointer `rr_ptr`: the first valid requester at index ≥ `rr_ptr` (wrapping) gets `req_ready`. Only one requester is granted per cycle, and nothing is granted when none is valid.
- On acceptance of requester g, `rr_ptr` ← (g+1) mod NUM_REQ. With no acceptance, `rr_ptr` holds.
- The accepted request is registered onto the bram_* outputs next cycle. `bram_en` is a one-cycle pulse per request; idle cycles drive `bram_en=0` and `bram_we=0`.
- Reads push a tag {valid, id} into a READ_LATENCY+1 deep shift register. When the tag emerges, `rsp_valid[id]` pulses and `rsp_rdata` holds the registered `bram_rdata`.
- Writes produce no response; acceptance is completion.
- There is no response backpressure; requesters must sink `rsp_valid` unconditionally.
- `rd_inflight` increments on read issue and decrements on `rsp_valid`. Both events in the same cycle leave it unchanged.
- Back-to-back reads from any mix of requesters are accepted every cycle, giving full pipelining.
- NUM_REQ=1: the grant is simply `req_valid[0]`, and `rr_ptr` is a constant 0.

## Timing
- Request accepted at cycle T → `bram_en` at T+1 → `bram_rdata` sampled at T+1+READ_LATENCY → `rsp_valid` and `rsp_rdata` at T+2+READ_LATENCY.
- A write accepted at T reaches the BRAM at T+1. A read to the same address accepted at T+1 returns the new data, because the BRAM is write-first in order.
- Reset values:
  - `req_ready` = 0 while reset is asserted.
  - `rsp_valid`, `bram_en` and `bram_we` = 0.
  - `rsp_rdata`, `bram_addr` and `bram_wdata` = 0.
  - `rd_inflight` = 0 and `rr_ptr` = 0.
- Reset asserted mid-operation clears the tag pipeline. In-flight reads never produce `rsp_valid`.
- `req_*` may change freely while `req_ready` is low. A requester holds its request stable until accepted.

## Configuration
- `BRAM_ARB_HIPRI_EN` defined: requester 0 (instruction cache) has absolute priority. When `req_valid[0]` is set it is granted regardless of `rr_ptr`, and `rr_ptr` is not updated. The remaining requesters round-robin among themselves.
- Not defined: pure round-robin across all NUM_REQ requesters.

## Structure
- Shared package `bram_arb_pkg`:
  - `ID_W = $clog2(NUM_REQ)` rule.
  - Tag struct {valid, id}.
  - Default ADDR_W, DATA_W and READ_LATENCY constants, shared with the BRAM controllers.
- Sub-module `rr_arbiter` (NUM_REQ): holds `rr_ptr`, takes `req`/`accept`, and outputs the one-hot grant plus the encoded id. The top holds the issue registers, tag pipeline and inflight counter.

## Test plan
- Single read: requester 2 reads addr 0x005 holding 0xDEADBEEF, accepted at T → `rsp_valid=4'b0100`, `rsp_rdata=0xDEADBEEF` at T+12 (READ_LATENCY=10); no other `rsp_valid` bit set.
- Fairness: all 4 requesters valid continuously for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; each `rsp_valid` id matches its issue order.
- Write-then-read: requester 3 writes 0x1234 to 0x010, then requester 1 reads 0x010 the next cycle → requester 1 receives 0x1234.
- HIPRI: with `BRAM_ARB_HIPRI_EN` defined, requesters 0 and 2 both valid for 3 cycles → requester 0 granted all 3 cycles and requester 2 on cycle 4. Without the macro → grants alternate 0,2,0,2.
- Reset mid-flight: 3 reads issued, `wb_rst_ni` pulsed low 5 cycles later → no `rsp_valid` thereafter, `rd_inflight=0`, next grant goes to requester 0.
- Counter: 10 back-to-back reads → `rd_inflight` peaks at 10 and returns to 0 exactly at the final `rsp_valid`.
